serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 112 +++++++++++
 tb/tb_serial_subtractor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial 4-bit subtractor: computes a - b - bin one bit per clock, LSB first,
// with a three-state IDLE/RUN/DONE controller and registered diff/bout results.
module serial_subtractor (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout,
  output logic       busy,
  output logic       done
);

  // Handshake: start is a level request sampled only in IDLE; the edge that
  // sees start=1 in IDLE captures a/b/bin, and done pulses for exactly one
  // cycle when diff/bout are valid. start is ignored in RUN and DONE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] res_q, res_d;
  logic       brw_q, brw_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] diff_q, diff_d;
  logic       bout_q, bout_d;

  logic       bit_d;
  logic       brw_nx;
  logic [3:0] res_shift;

  // One full-subtractor cell applied to the current LSBs.
  assign bit_d     = a_q[0] ^ b_q[0] ^ brw_q;
  assign brw_nx    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
  assign res_shift = {bit_d, res_q[3:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = 2'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d = res_shift;
        a_d   = {1'b0, a_q[3:1]};
        b_d   = {1'b0, b_q[3:1]};
        brw_d = brw_nx;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          // Last bit: publish the completed word on the same edge.
          diff_d  = res_shift;
          bout_d  = brw_nx;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      res_q   <= 4'd0;
      brw_q   <= 1'b0;
      cnt_q   <= 2'd0;
      diff_q  <= 4'd0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vectors, exhaustive and random sweeps
// against an arithmetic reference, start-in-RUN, back-to-back and reset abort.
module tb_serial_subtractor;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic [3:0] diff;
  logic       bout;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  // Expected {bout, diff} per launched operation, and the value the outputs
  // must keep holding until the next completion.
  logic [4:0] exp_q[$];
  logic [4:0] last_res;

  serial_subtractor dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [4:0] ref_model(input int av, input int bv, input int cv);
    int r;
    logic [4:0] res;
    r = av - bv - cv;
    res[3:0] = 4'((r + 32) % 16);
    res[4]   = (av < bv + cv);
    return res;
  endfunction

  // ---------------- driver: one complete operation ----------------
  task automatic do_op(input logic [3:0] av, input logic [3:0] bv, input logic cv);
    logic [4:0] exp;
    exp_q.push_back(ref_model(int'(av), int'(bv), int'(cv)));
    a = av; b = bv; bin = cv; start = 1'b1;
    tick();
    // Scramble operands after the accepting edge; they must not matter.
    start = 1'b0;
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    bin = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL run_flags op %0d-%0d-%0d cyc %0d: busy=%b done=%b, need busy=1 done=0",
                 av, bv, cv, i, busy, done);
      end
      checks++;
      if ({bout, diff} !== last_res) begin
        errors++;
        $display("FAIL hold_during_run op %0d-%0d-%0d cyc %0d: got %h, need %h",
                 av, bv, cv, i, {bout, diff}, last_res);
      end
      tick();
    end
    exp = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_latency op %0d-%0d-%0d: busy=%b done=%b, need busy=0 done=1",
               av, bv, cv, busy, done);
    end
    checks++;
    if ({bout, diff} !== exp) begin
      errors++;
      $display("FAIL result op %0d-%0d-%0d: bout=%b diff=%0d, need bout=%b diff=%0d",
               av, bv, cv, bout, diff, exp[4], exp[3:0]);
    end
    last_res = exp;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {bout, diff} !== last_res) begin
      errors++;
      $display("FAIL after_done op %0d-%0d-%0d: busy=%b done=%b res=%h, need 0 0 %h",
               av, bv, cv, busy, done, {bout, diff}, last_res);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0; bin = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 4'd0 || bout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b diff=%0d bout=%b, need all 0",
               busy, done, diff, bout);
    end
    reset = 1'b0;
    last_res = 5'd0;
    tick();
  endtask

  task automatic test_directed();
    do_op(4'd5,  4'd3,  1'b0);
    do_op(4'd3,  4'd5,  1'b0);
    do_op(4'd0,  4'd0,  1'b1);
    do_op(4'd15, 4'd15, 1'b1);
    do_op(4'd9,  4'd4,  1'b1);
  endtask

  task automatic test_reset_holds_start();
    reset = 1'b1; start = 1'b1; a = 4'd7; b = 4'd2; bin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== 4'd0 || bout !== 1'b0) begin
        errors++;
        $display("FAIL reset_ignores_start cyc %0d: busy=%b done=%b diff=%0d bout=%b, need all 0",
                 i, busy, done, diff, bout);
      end
    end
    start = 1'b0;
    reset = 1'b0;
    last_res = 5'd0;
    tick();
  endtask

  task automatic test_exhaustive();
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
          do_op(4'(ai), 4'(bi), 1'(ci));
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++)
      do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_start_in_run();
    a = 4'd5; b = 4'd3; bin = 1'b0; start = 1'b1;
    tick();
    a = 4'd0; b = 4'd0;
    // start stays high through RUN and DONE.
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (done !== 1'b1 || diff !== 4'd2 || bout !== 1'b0) begin
      errors++;
      $display("FAIL start_in_run_result: done=%b diff=%0d bout=%b, need 1 2 0", done, diff, bout);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done_ignored: busy=%b done=%b, need 0 0", busy, done);
    end
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || diff !== 4'd2 || bout !== 1'b0) begin
      errors++;
      $display("FAIL start_in_run_idle: busy=%b diff=%0d bout=%b, need 0 2 0", busy, diff, bout);
    end
    last_res = 5'd2;
  endtask

  task automatic test_back_to_back();
    logic exp_done, exp_busy;
    a = 4'd8; b = 4'd1; bin = 1'b0; start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_done = ((k % 6) == 4);
      exp_busy = ((k % 6) < 4);
      checks++;
      if (done !== exp_done || busy !== exp_busy) begin
        errors++;
        $display("FAIL back_to_back_timing cyc %0d: busy=%b done=%b, need %b %b",
                 k, busy, done, exp_busy, exp_done);
      end
      if (exp_done) begin
        checks++;
        if (diff !== 4'd7 || bout !== 1'b0) begin
          errors++;
          $display("FAIL back_to_back_result cyc %0d: diff=%0d bout=%b, need 7 0", k, diff, bout);
        end
      end
    end
    start = 1'b0;
    for (int k = 20; k < 26; k++) tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 4'd7 || bout !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_drain: busy=%b done=%b diff=%0d bout=%b, need 0 0 7 0",
               busy, done, diff, bout);
    end
    last_res = 5'd7;
  endtask

  task automatic test_reset_mid_run();
    a = 4'd3; b = 4'd5; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    // Now in the second RUN cycle.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 4'd0 || bout !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b done=%b diff=%0d bout=%b, need all 0",
               busy, done, diff, bout);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || diff !== 4'd0 || bout !== 1'b0) begin
        errors++;
        $display("FAIL reset_abort_quiet cyc %0d: busy=%b done=%b diff=%0d bout=%b, need all 0",
                 i, busy, done, diff, bout);
      end
    end
    last_res = 5'd0;
    // A fresh operation must still work after the abort.
    do_op(4'd9, 4'd4, 1'b1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    last_res = 5'd0;
    reset = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0; bin = 1'b0;

    test_reset();
    test_directed();
    test_reset_holds_start();
    test_exhaustive();
    test_random();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid_run();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, need 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound the run in case the sequence stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: sequence did not complete, need completion");
    $fatal(1, "timeout");
  end

endmodule
